// File: rtl/sprite_anim_fsm.sv
// Sprite animation controller: turns keyboard codes into walk/jump state, facing, motion and sprite index.
// Latency: outputs are registered and reflect a frame_tick on the same Clk edge that samples it.
// Backpressure: none; everything advances only on frame_tick edges and holds otherwise.
module sprite_anim_fsm #(
    parameter int KEY_LEFT       = 80,
    parameter int KEY_RIGHT      = 79,
    parameter int KEY_JUMP       = 82,
    parameter int TICKS_PER_STEP = 4,
    parameter int WALK_FRAMES    = 4,
    parameter int JUMP_TICKS     = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] Keycode,
    output logic [3:0] motion,
    output logic       facing,
    output logic [1:0] state,
    output logic [3:0] sprite_sel
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_JUMP = 2'd2
    } st_e;

    localparam logic [7:0] KEY_L       = 8'(KEY_LEFT);
    localparam logic [7:0] KEY_R       = 8'(KEY_RIGHT);
    localparam logic [7:0] KEY_J       = 8'(KEY_JUMP);
    localparam logic [7:0] STEP_LAST   = 8'(TICKS_PER_STEP - 1);
    localparam logic [7:0] FRAME_LAST  = 8'(WALK_FRAMES - 1);
    localparam logic [7:0] JUMP_LAST   = 8'(JUMP_TICKS - 1);
    localparam logic [7:0] JUMP_HALF   = 8'(JUMP_TICKS / 2);
    localparam logic [3:0] JUMP_SPRITE = 4'(WALK_FRAMES + 1);

    st_e        cur_st;
    st_e        nxt_st;
    logic [7:0] step_cnt;
    logic [7:0] step_nxt;
    logic [7:0] anim_frame;
    logic [7:0] anim_nxt;
    logic [7:0] jump_cnt;
    logic [7:0] jump_nxt;
    logic       facing_nxt;
    logic [3:0] motion_nxt;
    logic [3:0] sprite_nxt;

    logic is_left;
    logic is_right;
    logic is_jump;
    logic is_dir;

    // Left wins if the two direction keycodes were ever parameterised identically.
    assign is_left  = (Keycode == KEY_L);
    assign is_right = (Keycode == KEY_R) && !is_left;
    assign is_jump  = (Keycode == KEY_J) && !is_left && !is_right;
    assign is_dir   = is_left || is_right;

    assign state = cur_st;

    // State, counters and registered outputs; reset overrides any coincident tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_st     <= ST_IDLE;
            step_cnt   <= 8'd0;
            anim_frame <= 8'd0;
            jump_cnt   <= 8'd0;
            facing     <= 1'b0;
            motion     <= 4'b0000;
            sprite_sel <= 4'd0;
        end else begin
            cur_st     <= nxt_st;
            step_cnt   <= step_nxt;
            anim_frame <= anim_nxt;
            jump_cnt   <= jump_nxt;
            facing     <= facing_nxt;
            motion     <= motion_nxt;
            sprite_sel <= sprite_nxt;
        end
    end

    // Next state and counters; without a frame_tick everything holds.
    always_comb begin
        nxt_st     = cur_st;
        step_nxt   = step_cnt;
        anim_nxt   = anim_frame;
        jump_nxt   = jump_cnt;
        facing_nxt = facing;
        if (frame_tick) begin
            if (is_left) begin
                facing_nxt = 1'b1;
            end else if (is_right) begin
                facing_nxt = 1'b0;
            end
            case (cur_st)
                ST_IDLE: begin
                    if (is_dir) begin
                        nxt_st   = ST_WALK;
                        step_nxt = 8'd0;
                        anim_nxt = 8'd0;
                    end else if (is_jump) begin
                        nxt_st   = ST_JUMP;
                        jump_nxt = 8'd0;
                    end
                end
                ST_WALK: begin
                    if (is_dir) begin
                        // A direction flip keeps the stride going; only facing changes.
                        if (step_cnt == STEP_LAST) begin
                            step_nxt = 8'd0;
                            anim_nxt = (anim_frame == FRAME_LAST) ? 8'd0 : anim_frame + 8'd1;
                        end else begin
                            step_nxt = step_cnt + 8'd1;
                        end
                    end else if (is_jump) begin
                        nxt_st   = ST_JUMP;
                        jump_nxt = 8'd0;
                    end else begin
                        nxt_st   = ST_IDLE;
                        step_nxt = 8'd0;
                        anim_nxt = 8'd0;
                    end
                end
                ST_JUMP: begin
                    if (jump_cnt == JUMP_LAST) begin
                        // Landing: a held jump key does not re-trigger.
                        jump_nxt = 8'd0;
                        step_nxt = 8'd0;
                        anim_nxt = 8'd0;
                        nxt_st   = is_dir ? ST_WALK : ST_IDLE;
                    end else begin
                        jump_nxt = jump_cnt + 8'd1;
                    end
                end
                default: begin
                    nxt_st   = ST_IDLE;
                    step_nxt = 8'd0;
                    anim_nxt = 8'd0;
                    jump_nxt = 8'd0;
                end
            endcase
        end
    end

    // Output decode from the next-state values so outputs land on the sampling edge.
    always_comb begin
        motion_nxt = 4'b0000;
        sprite_nxt = 4'd0;
        case (nxt_st)
            ST_WALK: begin
                motion_nxt = {2'b00, ~facing_nxt, facing_nxt};
                sprite_nxt = anim_nxt[3:0] + 4'd1;
            end
            ST_JUMP: begin
                motion_nxt = (jump_nxt < JUMP_HALF) ? 4'b0100 : 4'b1000;
                sprite_nxt = JUMP_SPRITE;
            end
            default: begin
                motion_nxt = 4'b0000;
                sprite_nxt = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_anim_fsm.sv
// Scoreboard bench for sprite_anim_fsm with a behavioural model of the walk/jump rules.
// Latency: every driven cycle's expected outputs are checked just after the following Clk edge.
// Backpressure: none; the monitor pops one expectation per Clk edge while the queue is non-empty.
module tb_sprite_anim_fsm;

    localparam int TPS = 4;
    localparam int WF  = 4;
    localparam int JT  = 8;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] Keycode;
    logic [3:0] motion;
    logic       facing;
    logic [1:0] state;
    logic [3:0] sprite_sel;

    sprite_anim_fsm #(
        .KEY_LEFT(80), .KEY_RIGHT(79), .KEY_JUMP(82),
        .TICKS_PER_STEP(TPS), .WALK_FRAMES(WF), .JUMP_TICKS(JT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .Keycode(Keycode),
        .motion(motion), .facing(facing), .state(state), .sprite_sel(sprite_sel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] st;
        logic       fac;
        logic [3:0] mot;
        logic [3:0] spr;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: mode 0 idle, 1 walk, 2 jump; walk progress counted in total ticks walked.
    int m_mode;
    int m_fac;
    int m_walked;
    int m_age;

    task automatic model_reset();
        m_mode = 0; m_fac = 0; m_walked = 0; m_age = 0;
    endtask

    task automatic model_tick(input int key);
        bit dir;
        dir = (key == 80) || (key == 79);
        if (key == 80) m_fac = 1;
        else if (key == 79) m_fac = 0;
        if (m_mode == 0) begin
            if (dir) begin m_mode = 1; m_walked = 0; end
            else if (key == 82) begin m_mode = 2; m_age = 0; end
        end else if (m_mode == 1) begin
            if (dir) m_walked++;
            else if (key == 82) begin m_mode = 2; m_age = 0; end
            else m_mode = 0;
        end else begin
            if (m_age == JT - 1) begin
                if (dir) begin m_mode = 1; m_walked = 0; end
                else m_mode = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.st  = 2'(m_mode);
        e.fac = 1'(m_fac);
        e.tag = tag;
        if (m_mode == 1) begin
            e.mot = m_fac ? 4'b0001 : 4'b0010;
            e.spr = 4'(1 + (m_walked / TPS) % WF);
        end else if (m_mode == 2) begin
            e.mot = (m_age < JT / 2) ? 4'b0100 : 4'b1000;
            e.spr = 4'(WF + 1);
        end else begin
            e.mot = 4'b0000;
            e.spr = 4'd0;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected response.
    task automatic cycle(input bit rst, input bit tick, input int key, input string tag);
        @(negedge Clk);
        Reset      = rst;
        frame_tick = tick;
        Keycode    = 8'(key);
        if (rst) model_reset();
        else if (tick) model_tick(key);
        exp_q.push_back(model_out(tag));
    endtask

    task automatic ticks(input int n, input int key, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, key, tag);
    endtask

    task automatic chk(input string name, input string tag, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d, expected %0d at %0t", tag, name, act, req, $time);
        end
    endtask

    // Monitor: one expectation per Clk edge, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",      e.tag, int'(state),      int'(e.st));
                chk("facing",     e.tag, int'(facing),     int'(e.fac));
                chk("motion",     e.tag, int'(motion),     int'(e.mot));
                chk("sprite_sel", e.tag, int'(sprite_sel), int'(e.spr));
            end
        end
    end

    initial begin
        int keys[5];
        keys = '{0, 80, 79, 82, 17};
        Reset = 1'b1; frame_tick = 1'b0; Keycode = 8'd0;
        model_reset();

        // Reset dominates a tick with a key.
        cycle(1'b1, 1'b0, 0, "reset");
        cycle(1'b1, 1'b1, 80, "reset_tick");

        // Walk left: stride wraps after WF*TPS ticks; idle cycles hold.
        ticks(17, 80, "walk_left");
        cycle(1'b0, 1'b0, 82, "hold");
        cycle(1'b0, 1'b0, 0, "hold");

        // Left, right, release.
        cycle(1'b1, 1'b0, 0, "reset");
        ticks(10, 80, "dir_left");
        ticks(10, 79, "dir_right");
        ticks(10, 0, "dir_release");

        // Jump from idle, then release.
        ticks(1, 82, "jump");
        ticks(9, 0, "jump_fall");

        // Jump with right held to the landing; jump held to landing does not re-trigger.
        ticks(1, 82, "jump_r");
        ticks(9, 79, "jump_r");
        ticks(10, 82, "jump_hold");
        ticks(3, 0, "jump_hold");

        // Reset on the third jump tick, then a gap without ticks.
        ticks(2, 82, "jump_rst");
        cycle(1'b1, 1'b1, 82, "jump_rst");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 80, "frozen");

        // Randomised mix of keys, tick gaps and rare resets.
        for (int i = 0; i < 3000; i++) begin
            bit rst;
            bit tk;
            int k;
            rst = ($urandom_range(0, 199) == 0);
            tk  = ($urandom_range(0, 3) != 0);
            k   = keys[$urandom_range(0, 4)];
            if ($urandom_range(0, 3) != 0 && i > 0) k = int'(Keycode);
            cycle(rst, tk, k, "random");
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
